clock_divider_prog: RTL
=======================

CLOCK_DIVIDER_PROG -- requirements
Module: clock_divider_prog

Interface
REQ-001 SHALL have parameter CNT_W, default 16, meaning divisor/counter width in bits.
REQ-002 SHALL have parameter DEFAULT_DIV, default 100, meaning divisor loaded at reset (100 MHz -> 1 MHz).
REQ-003 SHALL have port clk_100MHz  input  1  sole clock, all logic on rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port enable  input  1  run request; high = generate clock.
REQ-006 SHALL have port div_in  input  CNT_W  requested divisor D.
REQ-007 SHALL have port div_load  input  1  one-cycle strobe, samples div_in.
REQ-008 SHALL have port div_ack  output  1  one-cycle pulse, divisor accepted.
REQ-009 SHALL have port div_err  output  1  one-cycle pulse, divisor rejected (D<2).
REQ-010 SHALL have port div_active  output  CNT_W  divisor currently in use.
REQ-011 SHALL have port clk_out  output  1  divided clock, registered.
REQ-012 SHALL have port tick  output  1  one-cycle pulse per clk_out period (only with CLKDIV_TICK_EN).

Function
REQ-013 SHALL implement states IDLE, RUN, with a separate pending flag plus pending divisor register.
REQ-014 SHALL use period counter cnt counting 0..D-1, D = div_active; H = D>>1 (integer).
REQ-015 SHALL, in RUN, drive clk_out high for cnt in 0..H-1 and low for cnt in H..D-1; period exactly D cycles; odd D gives low phase one cycle longer.
REQ-016 SHALL make clk_out a flop output, no combinational path from any input.
REQ-017 SHALL, in IDLE with enable high, enter RUN next cycle with cnt=0, clk_out=1.
REQ-018 SHALL, in IDLE, hold clk_out=0 and cnt=0.
REQ-019 SHALL, in RUN with enable low, complete current period and enter IDLE at cnt=D-1 instead of wrapping; no truncated pulse.
REQ-020 SHALL, on div_load with div_in>=2, pulse div_ack the following cycle.
REQ-021 SHALL, on div_load with div_in<2, pulse div_err the following cycle and leave div_active and pending unchanged.
REQ-022 SHALL, when an accepted load occurs in IDLE, update div_active the following cycle.
REQ-023 SHALL, when an accepted load occurs in RUN, store it as pending and apply it at the next wrap (cnt D-1 -> 0); div_active changes in the same cycle cnt becomes 0.
REQ-024 SHALL, for a load coinciding with a wrap cycle, defer it to the following wrap; the current wrap uses the previous pending value if any.
REQ-025 SHALL, for a second accepted load before the pending one applies, overwrite pending; each load acked individually.
REQ-026 SHALL, for enable low while pending is set, apply pending on entry to IDLE.
REQ-027 SHALL support any D in 2..2^CNT_W-1 with no overflow; cnt compare uses full CNT_W width.

Reset
REQ-028 SHALL, while rst high, force state=IDLE, cnt=0, clk_out=0, tick=0, div_ack=0, div_err=0, pending cleared, div_active=DEFAULT_DIV.
REQ-029 SHALL ignore div_load and enable in any cycle rst is high; rst mid-period aborts the period immediately.

Configuration
REQ-030 SHALL, with macro CLKDIV_TICK_EN defined, provide tick, registered, high exactly in the cycle clk_out rises (cnt=0 in RUN).
REQ-031 SHALL, without CLKDIV_TICK_EN, omit the tick port and its logic; all other behaviour identical.

Verification
REQ-032 SHALL cover: rst then enable=1, no load -> clk_out period 100 cycles, 50 high/50 low, div_active=100.
REQ-033 SHALL cover: load div_in=7 in RUN -> div_ack next cycle; current 100-cycle period completes, then periods of 7 (3 high/4 low).
REQ-034 SHALL cover: load div_in=1, then 0 -> div_err pulses twice, div_active unchanged, clk_out unaffected.
REQ-035 SHALL cover: enable dropped at cnt=10 with D=20 -> clk_out low from cnt=10, IDLE after cnt=19, no further edges.
REQ-036 SHALL cover: loads 5 then 9 within one D=100 period -> two div_acks, next period uses 9; load coinciding with wrap takes effect one period later.
REQ-037 SHALL cover: rst asserted mid-high-phase with pending=3 -> clk_out=0 next cycle, div_active=100, pending discarded; tick pulses once per period when CLKDIV_TICK_EN defined.

Source files
------------

// File: rtl/clock_divider_prog.sv
// clock_divider_prog
//   Programmable clock divider. Produces clk_out with a period of exactly
//   div_active input-clock cycles: high for the first D>>1 counts, low for the
//   rest (odd divisors get the extra cycle in the low phase). A new divisor
//   can be requested at any time. It is rejected when below 2. When accepted,
//   it is applied at once while idle, or at the next period boundary while
//   running, so clk_out never shows a truncated pulse.
//
//   Optional feature macro: CLKDIV_TICK_EN
//     When defined, a registered 'tick' output pulses in the cycle clk_out rises.
//
// Ports
//   clk_100MHz  in   sole clock, rising edge
//   rst         in   synchronous active-high reset
//   enable      in   run request
//   div_in      in   requested divisor (CNT_W bits)
//   div_load    in   one-cycle strobe, samples div_in
//   div_ack     out  one-cycle pulse, divisor accepted
//   div_err     out  one-cycle pulse, divisor rejected (div_in < 2)
//   div_active  out  divisor currently in use
//   clk_out     out  divided clock, registered
//   tick        out  period-start pulse (CLKDIV_TICK_EN only)

module clock_divider_prog #(
  parameter int          CNT_W       = 16,
  parameter int unsigned DEFAULT_DIV = 100
) (
  input  logic             clk_100MHz,
  input  logic             rst,
  input  logic             enable,
  input  logic [CNT_W-1:0] div_in,
  input  logic             div_load,
  output logic             div_ack,
  output logic             div_err,
  output logic [CNT_W-1:0] div_active,
  output logic             clk_out
`ifdef CLKDIV_TICK_EN
  ,
  output logic             tick
`endif
);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] div_active_q, div_active_d;
  logic             pend_valid_q, pend_valid_d;
  logic [CNT_W-1:0] pend_div_q, pend_div_d;
  logic             div_ack_q, div_ack_d;
  logic             div_err_q, div_err_d;
  logic             clk_out_q, clk_out_d;
  logic             load_ok, load_bad, wrap;
`ifdef CLKDIV_TICK_EN
  logic             tick_q, tick_d;
`endif

  assign load_ok  = div_load && (div_in >= CNT_W'(2));
  assign load_bad = div_load && (div_in <  CNT_W'(2));
  // Last count of the current period; div_active is always >= 2, so no underflow.
  assign wrap     = (state_q == RUN) && (cnt_q == (div_active_q - CNT_W'(1)));

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    div_active_d = div_active_q;
    pend_valid_d = pend_valid_q;
    pend_div_d   = pend_div_q;
    div_ack_d    = 1'b0;
    div_err_d    = 1'b0;

    case (state_q)
      IDLE: begin
        cnt_d = '0;
        // Catches a divisor that became pending in the cycle IDLE was entered.
        if (pend_valid_q) begin
          div_active_d = pend_div_q;
          pend_valid_d = 1'b0;
        end
        if (enable) state_d = RUN;
      end
      RUN: begin
        if (wrap) begin
          cnt_d = '0;
          if (pend_valid_q) begin
            div_active_d = pend_div_q;
            pend_valid_d = 1'b0;
          end
          // Enable is only honoured at a period boundary.
          if (!enable) state_d = IDLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase

    // A load placed after the wrap handling lands in pending, so a load during
    // a wrap cycle waits one full period while the older pending value applies.
    if (load_ok) begin
      div_ack_d = 1'b1;
      if (state_q == IDLE) begin
        div_active_d = div_in;
        pend_valid_d = 1'b0;
      end else begin
        pend_valid_d = 1'b1;
        pend_div_d   = div_in;
      end
    end
    if (load_bad) div_err_d = 1'b1;

    // Output is derived from next-state values so it lines up with cnt.
    clk_out_d = (state_d == RUN) && (cnt_d < (div_active_d >> 1));
  end

`ifdef CLKDIV_TICK_EN
  assign tick_d = (state_d == RUN) && (cnt_d == '0);
`endif

  always_ff @(posedge clk_100MHz) begin
    if (rst) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      div_active_q <= CNT_W'(DEFAULT_DIV);
      pend_valid_q <= 1'b0;
      pend_div_q   <= '0;
      div_ack_q    <= 1'b0;
      div_err_q    <= 1'b0;
      clk_out_q    <= 1'b0;
`ifdef CLKDIV_TICK_EN
      tick_q       <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      div_active_q <= div_active_d;
      pend_valid_q <= pend_valid_d;
      pend_div_q   <= pend_div_d;
      div_ack_q    <= div_ack_d;
      div_err_q    <= div_err_d;
      clk_out_q    <= clk_out_d;
`ifdef CLKDIV_TICK_EN
      tick_q       <= tick_d;
`endif
    end
  end

  assign div_ack    = div_ack_q;
  assign div_err    = div_err_q;
  assign div_active = div_active_q;
  assign clk_out    = clk_out_q;
`ifdef CLKDIV_TICK_EN
  assign tick       = tick_q;
`endif

endmodule
